uart_sample_rx: RTL and testbench

Receives the 4-channel sample stream that the board's UART monitor emits and reconstructs the per-channel 16-bit sample words. Frame format, 5 bytes per channel: 'C' (0x43), 'H' (0x48), ASCII channel id '0'..'3' (0x30..0x33), sample MSB, sample LSB. UART format is 8N1, LSB first, idle high. Used in loopback and regression benches, and on a second board to drive sample_in* of the sample/codec path from a serial stream.

---
 rtl/uart_sample_pkg.sv | 28 ++
 rtl/uart_rx_byte.sv | 111 +++++++++++
 rtl/uart_sample_rx.sv | 111 +++++++++++
 tb/tb_uart_sample_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_sample_pkg.sv
// Shared types, ASCII framing constants and baud helper for the UART sample receiver.
package uart_sample_pkg;

  typedef enum logic [2:0] {
    P_HUNT,
    P_GOT_C,
    P_GOT_H,
    P_GET_MSB,
    P_GET_LSB
  } parse_state_e;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_e;

  localparam logic [7:0] CH_C   = 8'h43;
  localparam logic [7:0] CH_H   = 8'h48;
  localparam logic [7:0] CH_ID0 = 8'h30;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling FSM, LSB-first shifter.
module uart_rx_byte
  import uart_sample_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned   CW      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta_q, rx_s_q, rx_prev_q;
  byte_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  // Synchronise rx and keep the previous synchronised value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Byte FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= B_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: half-bit wait to centre on the start bit, then full-bit steps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      B_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = B_START;
          cnt_d   = '0;
        end
      end
      B_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? B_IDLE : B_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      B_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = B_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      B_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = B_IDLE;
          if (rx_s_q) valid_d = 1'b1;
          else        ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = B_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_sample_rx.sv
// Reassembles "CH<n>" + MSB + LSB frames from the UART byte stream into four sample registers.
module uart_sample_rx
  import uart_sample_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] sample_out0,
  output logic [15:0] sample_out1,
  output logic [15:0] sample_out2,
  output logic [15:0] sample_out3,
  output logic        sample_valid,
  output logic [1:0]  sample_ch,
  output logic        frame_err
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);

  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_ferr;

  parse_state_e state_q, state_d;
  logic [1:0]   ch_q, ch_d;
  logic [7:0]   msb_q, msb_d;
  logic         commit;
  logic [15:0]  samp_q [4];
  logic         valid_q;
  logic [1:0]   sch_q;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_byte (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (byte_ferr)
  );

  // Parser state, header fields, sample registers and output pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= P_HUNT;
      ch_q    <= '0;
      msb_q   <= '0;
      samp_q  <= '{default: '0};
      valid_q <= 1'b0;
      sch_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      msb_q   <= msb_d;
      valid_q <= commit;
      if (commit) begin
        samp_q[ch_q] <= {msb_q, byte_data};
        sch_q        <= ch_q;
      end
    end
  end

  // Header matcher; a framing error abandons any partial frame.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    msb_d   = msb_q;
    commit  = 1'b0;
    if (byte_ferr) begin
      state_d = P_HUNT;
    end else if (byte_valid) begin
      unique case (state_q)
        P_HUNT:  if (byte_data == CH_C) state_d = P_GOT_C;
        P_GOT_C: begin
          if      (byte_data == CH_H) state_d = P_GOT_H;
          else if (byte_data == CH_C) state_d = P_GOT_C;
          else                        state_d = P_HUNT;
        end
        P_GOT_H: begin
          if (byte_data[7:2] == CH_ID0[7:2]) begin
            ch_d    = byte_data[1:0];
            state_d = P_GET_MSB;
          end else if (byte_data == CH_C) begin
            state_d = P_GOT_C;
          end else begin
            state_d = P_HUNT;
          end
        end
        P_GET_MSB: begin
          msb_d   = byte_data;
          state_d = P_GET_LSB;
        end
        P_GET_LSB: begin
          commit  = 1'b1;
          state_d = P_HUNT;
        end
        default: state_d = P_HUNT;
      endcase
    end
  end

  assign sample_out0  = samp_q[0];
  assign sample_out1  = samp_q[1];
  assign sample_out2  = samp_q[2];
  assign sample_out3  = samp_q[3];
  assign sample_valid = valid_q;
  assign sample_ch    = sch_q;
  assign frame_err    = byte_ferr;

endmodule

// File: tb/tb_uart_sample_rx.sv
// Scoreboard bench for uart_sample_rx: directed frames, monitor pops expected samples on sample_valid.
`timescale 1ns/1ps
module tb_uart_sample_rx;

  localparam int unsigned CPB = 12_000_000 / 115200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [15:0] sample_out0, sample_out1, sample_out2, sample_out3;
  logic        sample_valid;
  logic [1:0]  sample_ch;
  logic        frame_err;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] model [4];
  int          errors    = 0;
  int          checks    = 0;
  int          ferr_seen = 0;

  uart_sample_rx #(.CLK_FREQ(12_000_000), .BAUD(115200)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .sample_out0  (sample_out0),
    .sample_out1  (sample_out1),
    .sample_out2  (sample_out2),
    .sample_out3  (sample_out3),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .frame_err    (frame_err)
  );

  always #41.667 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: count frame errors, pop and compare on every sample_valid.
  always @(negedge clk) begin
    if (rst) begin
      model = '{default: '0};
    end else begin
      if (frame_err) ferr_seen++;
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(sample_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          model[e.ch] = e.val;
          chk("sample_ch",   32'(sample_ch),   32'(e.ch));
          chk("sample_out0", 32'(sample_out0), 32'(model[0]));
          chk("sample_out1", 32'(sample_out1), 32'(model[1]));
          chk("sample_out2", 32'(sample_out2), 32'(model[2]));
          chk("sample_out3", 32'(sample_out3), 32'(model[3]));
        end
      end
    end
  end

  task automatic idle_bits(input int unsigned n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [15:0] val, input bit expect_commit);
    logic [1:0] c;
    c = id[1:0];
    if (expect_commit) exp_q.push_back('{ch: c, val: val});
    send_byte(8'h43, 1'b1);
    send_byte(8'h48, 1'b1);
    send_byte(id, 1'b1);
    send_byte(val[15:8], 1'b1);
    send_byte(val[7:0], 1'b1);
  endtask

  task automatic drain(input string nm);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out0",  32'(sample_out0),  32'd0);
    chk("rst_out1",  32'(sample_out1),  32'd0);
    chk("rst_out2",  32'(sample_out2),  32'd0);
    chk("rst_out3",  32'(sample_out3),  32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_ch",    32'(sample_ch),    32'd0);
    chk("rst_ferr",  32'(frame_err),    32'd0);
    rst = 1'b0;
    idle_bits(2);

    // Single channel-0 frame.
    send_frame(8'h30, 16'h1234, 1'b1);
    idle_bits(1);
    drain("t1_drain");

    // Four channels back to back, no idle between bytes.
    send_frame(8'h30, 16'h8000, 1'b1);
    send_frame(8'h31, 16'h7FFF, 1'b1);
    send_frame(8'h32, 16'h0043, 1'b1);
    send_frame(8'h33, 16'hFFFF, 1'b1);
    idle_bits(1);
    drain("t2_drain");

    // Repeated 'C' before header, payload bytes equal to 'C' and 'H'.
    exp_q.push_back('{ch: 2'd2, val: 16'h4348});
    send_byte(8'h43, 1'b1);
    send_byte(8'h43, 1'b1);
    send_byte(8'h48, 1'b1);
    send_byte(8'h32, 1'b1);
    send_byte(8'h43, 1'b1);
    send_byte(8'h48, 1'b1);
    idle_bits(1);
    drain("t3_drain");

    // Bad channel id is ignored, following good frame accepted.
    send_frame(8'h35, 16'hAABB, 1'b0);
    idle_bits(1);
    send_frame(8'h31, 16'h0001, 1'b1);
    idle_bits(1);
    drain("t4_drain");

    // Stop bit low on the MSB byte of a channel-3 frame.
    send_byte(8'h43, 1'b1);
    send_byte(8'h48, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h99, 1'b0);
    idle_bits(2);
    chk("t5_ferr_count", 32'(ferr_seen), 32'd1);
    send_byte(8'h11, 1'b1);
    idle_bits(1);
    send_frame(8'h33, 16'h5AA5, 1'b1);
    idle_bits(1);
    drain("t5_drain");

    // Short low glitch: no byte, no frame error.
    @(negedge clk);
    #10 rx = 1'b0;
    #20 rx = 1'b1;
    idle_bits(2);
    drain("t6_glitch_novalid");
    chk("t6_glitch_ferr", 32'(ferr_seen), 32'd1);

    // Reset in the middle of a frame.
    send_byte(8'h43, 1'b1);
    send_byte(8'h48, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'h12, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_out0",  32'(sample_out0),  32'd0);
    chk("mid_rst_out1",  32'(sample_out1),  32'd0);
    chk("mid_rst_out2",  32'(sample_out2),  32'd0);
    chk("mid_rst_out3",  32'(sample_out3),  32'd0);
    chk("mid_rst_valid", 32'(sample_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_bits(1);
    send_byte(8'h34, 1'b1);
    idle_bits(1);
    drain("post_rst_nocommit");
    chk("post_rst_out0", 32'(sample_out0), 32'd0);
    send_frame(8'h30, 16'hBEEF, 1'b1);
    idle_bits(1);
    drain("post_rst_recover");
    chk("final_ferr_count", 32'(ferr_seen), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
